// File: rtl/am_align_ctrl_if.sv
// Status/control bundle between the AM lock top level (master) and am_align_ctrl (slave).
// Members keep the controller's i_/o_ names, so both sides read the same as the port list.
interface am_align_ctrl_if #(
    parameter int N_LANES         = 20,
    parameter int NB_TIMEOUT      = 16,
    parameter int NB_LOSS_COUNTER = 8
);
    localparam int NB_LANE_ID = $clog2(N_LANES);
    localparam int NB_ID_BUS  = N_LANES * NB_LANE_ID;

    logic                       i_enable;
    logic                       i_valid;
    logic [N_LANES-1:0]         i_block_lock;
    logic [N_LANES-1:0]         i_am_lock;
    logic [NB_ID_BUS-1:0]       i_lane_id;
    logic [NB_TIMEOUT-1:0]      i_rf_timeout;
    logic                       o_aligner_enable;
    logic                       o_restart;
    logic                       o_deskew_enable;
    logic                       o_align_status;
    logic                       o_id_error;
    logic [NB_LOSS_COUNTER-1:0] o_loss_counter;
    logic [2:0]                 o_state;

    modport master (
        output i_enable, i_valid, i_block_lock, i_am_lock, i_lane_id, i_rf_timeout,
        input  o_aligner_enable, o_restart, o_deskew_enable, o_align_status,
               o_id_error, o_loss_counter, o_state
    );

    modport slave (
        input  i_enable, i_valid, i_block_lock, i_am_lock, i_lane_id, i_rf_timeout,
        output o_aligner_enable, o_restart, o_deskew_enable, o_align_status,
               o_id_error, o_loss_counter, o_state
    );
endinterface

// File: rtl/am_align_ctrl.sv
// Supervisory FSM for the 20-lane AM lock stage: block lock -> AM lock -> lane-ID check -> aligned.
// Define ALIGN_CTRL_HYST_EN to require 3 consecutive valid loss cycles before leaving ALIGNED.
module am_align_ctrl #(
    parameter int N_LANES         = 20,
    parameter int NB_LANE_ID      = $clog2(N_LANES),
    parameter int NB_ID_BUS       = N_LANES * NB_LANE_ID,
    parameter int NB_TIMEOUT      = 16,
    parameter int NB_LOSS_COUNTER = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    am_align_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_BLOCK = 3'd1;
    localparam logic [2:0] ST_WAIT_AM    = 3'd2;
    localparam logic [2:0] ST_CHECK_ID   = 3'd3;
    localparam logic [2:0] ST_ALIGNED    = 3'd4;
    localparam logic [2:0] ST_RESTART    = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [NB_TIMEOUT-1:0]      timeout_cnt_q, timeout_cnt_d;
    logic [NB_LOSS_COUNTER-1:0] loss_cnt_q, loss_cnt_d;
    logic                       id_error_q, id_error_d;
    logic                       aligner_enable_q, aligner_enable_d;
    logic                       restart_q, restart_d;
    logic                       deskew_enable_q, deskew_enable_d;
    logic                       align_status_q, align_status_d;
`ifdef ALIGN_CTRL_HYST_EN
    logic [1:0]                 hyst_cnt_q, hyst_cnt_d;
`endif

    logic [NB_LANE_ID-1:0] lane_id [N_LANES];
    logic [N_LANES-1:0]    id_map;
    logic                  id_range_ok;
    logic                  ids_ok;
    logic                  all_block_lock;
    logic                  all_am_lock;
    logic                  lane_loss;
    logic [NB_TIMEOUT:0]   timeout_next;
    logic                  timeout_hit;

    // Lane 0 occupies the most significant slice of the packed ID bus.
    always_comb begin
        for (int lane = 0; lane < N_LANES; lane++) begin
            lane_id[lane] = bus.i_lane_id[NB_ID_BUS-1-lane*NB_LANE_ID -: NB_LANE_ID];
        end
    end

    // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
    always_comb begin
        id_map      = '0;
        id_range_ok = 1'b1;
        for (int lane = 0; lane < N_LANES; lane++) begin
            if (int'(lane_id[lane]) < N_LANES) begin
                id_map[lane_id[lane]] = 1'b1;
            end else begin
                id_range_ok = 1'b0;
            end
        end
    end

    assign ids_ok         = id_range_ok && (&id_map);
    assign all_block_lock = &bus.i_block_lock;
    assign all_am_lock    = &bus.i_am_lock;
    assign lane_loss      = !all_block_lock || !all_am_lock;
    assign timeout_next   = {1'b0, timeout_cnt_q} + {{NB_TIMEOUT{1'b0}}, 1'b1};
    assign timeout_hit    = (bus.i_rf_timeout != '0) && bus.i_valid &&
                            (timeout_next >= {1'b0, bus.i_rf_timeout});

    always_comb begin
        state_d       = state_q;
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        id_error_d    = id_error_q;
`ifdef ALIGN_CTRL_HYST_EN
        hyst_cnt_d    = hyst_cnt_q;
`endif
        if (!bus.i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_BLOCK;
                ST_WAIT_BLOCK: begin
                    if (all_block_lock) begin
                        state_d       = ST_WAIT_AM;
                        timeout_cnt_d = '0;
                    end
                end
                ST_WAIT_AM: begin
                    if (bus.i_valid && (timeout_cnt_q != '1)) begin
                        timeout_cnt_d = timeout_next[NB_TIMEOUT-1:0];
                    end
                    // AM lock wins over a timeout landing in the same cycle.
                    if (!all_block_lock)  state_d = ST_WAIT_BLOCK;
                    else if (all_am_lock) state_d = ST_CHECK_ID;
                    else if (timeout_hit) state_d = ST_RESTART;
                end
                ST_CHECK_ID: begin
                    if (ids_ok) begin
                        state_d    = ST_ALIGNED;
                        id_error_d = 1'b0;
`ifdef ALIGN_CTRL_HYST_EN
                        hyst_cnt_d = '0;
`endif
                    end else begin
                        state_d    = ST_RESTART;
                        id_error_d = 1'b1;
                    end
                end
                ST_ALIGNED: begin
`ifdef ALIGN_CTRL_HYST_EN
                    if (bus.i_valid) begin
                        if (!lane_loss) begin
                            hyst_cnt_d = '0;
                        end else if (hyst_cnt_q == 2'd2) begin
                            hyst_cnt_d = '0;
                            state_d    = ST_RESTART;
                            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + NB_LOSS_COUNTER'(1);
                        end else begin
                            hyst_cnt_d = hyst_cnt_q + 2'd1;
                        end
                    end
`else
                    if (lane_loss) begin
                        state_d = ST_RESTART;
                        if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + NB_LOSS_COUNTER'(1);
                    end
`endif
                end
                ST_RESTART: state_d = ST_WAIT_BLOCK;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    assign aligner_enable_d = state_d inside {ST_WAIT_AM, ST_CHECK_ID, ST_ALIGNED};
    assign restart_d        = (state_d == ST_RESTART);
    assign deskew_enable_d  = (state_d == ST_ALIGNED);
    assign align_status_d   = (state_d == ST_ALIGNED);

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q          <= ST_IDLE;
            timeout_cnt_q    <= '0;
            loss_cnt_q       <= '0;
            id_error_q       <= 1'b0;
            aligner_enable_q <= 1'b0;
            restart_q        <= 1'b0;
            deskew_enable_q  <= 1'b0;
            align_status_q   <= 1'b0;
`ifdef ALIGN_CTRL_HYST_EN
            hyst_cnt_q       <= '0;
`endif
        end else begin
            state_q          <= state_d;
            timeout_cnt_q    <= timeout_cnt_d;
            loss_cnt_q       <= loss_cnt_d;
            id_error_q       <= id_error_d;
            aligner_enable_q <= aligner_enable_d;
            restart_q        <= restart_d;
            deskew_enable_q  <= deskew_enable_d;
            align_status_q   <= align_status_d;
`ifdef ALIGN_CTRL_HYST_EN
            hyst_cnt_q       <= hyst_cnt_d;
`endif
        end
    end

    assign bus.o_aligner_enable = aligner_enable_q;
    assign bus.o_restart        = restart_q;
    assign bus.o_deskew_enable  = deskew_enable_q;
    assign bus.o_align_status   = align_status_q;
    assign bus.o_id_error       = id_error_q;
    assign bus.o_loss_counter   = loss_cnt_q;
    assign bus.o_state          = state_q;
endmodule

// File: tb/tb_am_align_ctrl.sv
// Directed bench for am_align_ctrl: lock sequencing, ID check, timeout, loss counting, enable and reset.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_am_align_ctrl;
    localparam int N_LANES   = 20;
    localparam int NB_ID_BUS = 100;
`ifdef ALIGN_CTRL_HYST_EN
    localparam int LOSS_CYCLES = 3;
`else
    localparam int LOSS_CYCLES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [NB_ID_BUS-1:0] ids_ok;
    logic [NB_ID_BUS-1:0] ids_dup;

    am_align_ctrl_if bus ();

    am_align_ctrl dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold one lane's AM lock low long enough to force a RESTART from ALIGNED.
    task automatic lose_lock();
        bus.i_am_lock[3] = 1'b0;
        repeat (LOSS_CYCLES) step();
        bus.i_am_lock = '1;
    endtask

    // RESTART -> WAIT_BLOCK -> WAIT_AM -> CHECK_ID -> ALIGNED with all locks present.
    task automatic recover();
        repeat (4) step();
    endtask

    initial begin
        for (int lane = 0; lane < N_LANES; lane++) begin
            ids_ok[NB_ID_BUS-1-lane*5 -: 5] = 5'(lane);
        end
        ids_dup = ids_ok;
        ids_dup[NB_ID_BUS-1-5*5 -: 5] = 5'd6;

        bus.i_enable     = 1'b0;
        bus.i_valid      = 1'b1;
        bus.i_block_lock = '0;
        bus.i_am_lock    = '0;
        bus.i_lane_id    = ids_ok;
        bus.i_rf_timeout = '0;

        step();
        step();
        check("rst_state", 32'(bus.o_state), 0);
        check("rst_outs", {bus.o_aligner_enable, bus.o_restart, bus.o_deskew_enable,
                           bus.o_align_status, bus.o_id_error}, 0);
        check("rst_loss", 32'(bus.o_loss_counter), 0);

        // Normal lock-up path.
        rst = 1'b0;
        bus.i_enable     = 1'b1;
        bus.i_block_lock = '1;
        step();
        check("t1_wait_block", 32'(bus.o_state), 1);
        check("t1_wb_aen", 32'(bus.o_aligner_enable), 0);
        step();
        check("t1_wait_am", 32'(bus.o_state), 2);
        check("t1_wam_aen", 32'(bus.o_aligner_enable), 1);
        bus.i_am_lock = '1;
        step();
        check("t1_check_id", 32'(bus.o_state), 3);
        check("t1_chk_deskew", 32'(bus.o_deskew_enable), 0);
        step();
        check("t1_aligned", 32'(bus.o_state), 4);
        check("t1_status", {bus.o_align_status, bus.o_deskew_enable, bus.o_aligner_enable}, 3'b111);
        check("t1_id_error", 32'(bus.o_id_error), 0);

`ifdef ALIGN_CTRL_HYST_EN
        bus.i_am_lock[3] = 1'b0;
        step();
        step();
        check("hyst_2drop", 32'(bus.o_state), 4);
        bus.i_am_lock = '1;
        step();
        check("hyst_clean", 32'(bus.o_state), 4);
        bus.i_am_lock[3] = 1'b0;
        bus.i_valid      = 1'b0;
        repeat (4) step();
        check("hyst_novalid", 32'(bus.o_state), 4);
        bus.i_am_lock = '1;
        bus.i_valid   = 1'b1;
        step();
        check("hyst_loss_hold", 32'(bus.o_loss_counter), 0);
`endif

        // First alignment loss.
        lose_lock();
        check("t4_restart_state", 32'(bus.o_state), 5);
        check("t4_restart_pulse", {bus.o_restart, bus.o_aligner_enable, bus.o_align_status}, 3'b100);
        check("t4_loss1", 32'(bus.o_loss_counter), 1);

        // Block lock drop in WAIT_AM returns to WAIT_BLOCK without counting a loss.
        bus.i_am_lock = '0;
        step();
        check("t4_after_restart", {29'd0, bus.o_state}, 1);
        check("t4_pulse_done", 32'(bus.o_restart), 0);
        step();
        check("t6_wait_am", 32'(bus.o_state), 2);
        bus.i_block_lock[0] = 1'b0;
        step();
        check("t6_blk_drop", 32'(bus.o_state), 1);
        check("t6_blk_loss", 32'(bus.o_loss_counter), 1);
        check("t6_blk_aen", 32'(bus.o_aligner_enable), 0);
        bus.i_block_lock = '1;
        bus.i_am_lock    = '1;
        repeat (3) step();
        check("t4_realigned", 32'(bus.o_state), 4);

        // Saturation of the loss counter across 300 losses.
        for (int n = 0; n < 253; n++) begin
            lose_lock();
            recover();
        end
        check("t4_loss254", 32'(bus.o_loss_counter), 254);
        lose_lock();
        check("t4_loss255", 32'(bus.o_loss_counter), 255);
        for (int n = 0; n < 45; n++) begin
            recover();
            lose_lock();
        end
        check("t4_loss_sat", 32'(bus.o_loss_counter), 255);
        check("t4_sat_state", 32'(bus.o_state), 5);

        // Duplicate lane IDs (lanes 5 and 6 both report 6).
        bus.i_lane_id = ids_dup;
        repeat (3) step();
        check("t2_check_id", 32'(bus.o_state), 3);
        step();
        check("t2_restart", 32'(bus.o_state), 5);
        check("t2_pulse", {bus.o_restart, bus.o_id_error}, 2'b11);
        check("t2_no_loss", 32'(bus.o_loss_counter), 255);
        step();
        check("t2_wait_block", 32'(bus.o_state), 1);
        check("t2_pulse_1cyc", 32'(bus.o_restart), 0);
        check("t2_sticky", 32'(bus.o_id_error), 1);

        // AM-lock timeout of 10 valid cycles with a non-valid gap.
        bus.i_am_lock    = '0;
        bus.i_lane_id    = ids_ok;
        bus.i_rf_timeout = 16'd10;
        step();
        check("t3_wait_am", 32'(bus.o_state), 2);
        repeat (5) step();
        bus.i_valid = 1'b0;
        repeat (3) step();
        bus.i_valid = 1'b1;
        repeat (4) step();
        check("t3_before_to", 32'(bus.o_state), 2);
        step();
        check("t3_timeout", 32'(bus.o_state), 5);
        check("t3_pulse", 32'(bus.o_restart), 1);

        // Zero timeout never expires.
        bus.i_rf_timeout = '0;
        step();
        step();
        check("t3_wam_again", 32'(bus.o_state), 2);
        repeat (100) step();
        check("t3_no_timeout", 32'(bus.o_state), 2);

        // Enable drop in WAIT_AM.
        bus.i_enable = 1'b0;
        step();
        check("t5_idle", 32'(bus.o_state), 0);
        check("t5_outs", {bus.o_aligner_enable, bus.o_restart}, 0);
        check("t5_hold", {bus.o_id_error, bus.o_loss_counter}, 9'h1ff);
        step();
        check("t5_no_pulse", 32'(bus.o_restart), 0);

        // Realign, then reset from ALIGNED.
        bus.i_enable  = 1'b1;
        bus.i_am_lock = '1;
        repeat (4) step();
        check("t6_aligned", 32'(bus.o_state), 4);
        check("t6_id_clear", 32'(bus.o_id_error), 0);
        rst = 1'b1;
        step();
        check("t6_rst_state", 32'(bus.o_state), 0);
        check("t6_rst_outs", {bus.o_aligner_enable, bus.o_restart, bus.o_deskew_enable,
                              bus.o_align_status, bus.o_id_error}, 0);
        check("t6_rst_loss", 32'(bus.o_loss_counter), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/am_align_ctrl.md
Name: am_align_ctrl

Overview:
Supervisory controller for the 20-lane alignment-marker lock stage. It sequences the per-lane AM lock modules through four phases: waiting for block lock, waiting for AM lock, lane-ID verification, and aligned operation. It gates the aligners' enable, issues restart pulses, and qualifies the downstream deskew/reorder stage. It sits beside the AM lock top level, consuming its lock/lane-ID status and driving its enable/reset.

Parameters:
N_LANES, 20, number of PCS lanes
NB_LANE_ID, $clog2(N_LANES), lane-ID width per lane
NB_ID_BUS, N_LANES*NB_LANE_ID, packed lane-ID bus width
NB_TIMEOUT, 16, AM-lock timeout counter width
NB_LOSS_COUNTER, 8, alignment-loss event counter width

Ports:
i_clock  in  1  single clock for all logic
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  register-file enable for the controller
i_valid  in  1  datapath valid qualifier; timeout counts only on valid cycles
i_block_lock  in  N_LANES  per-lane block lock
i_am_lock  in  N_LANES  per-lane AM lock from the aligners
i_lane_id  in  NB_ID_BUS  packed detected lane IDs; lane 0 in the MSBs
i_rf_timeout  in  NB_TIMEOUT  AM-lock timeout in valid cycles; 0 disables the timeout
o_aligner_enable  out  1  enable to all AM lock modules
o_restart  out  1  one-cycle reset pulse to the aligners
o_deskew_enable  out  1  enable for the deskew/reorder stage
o_align_status  out  1  global PCS alignment status
o_id_error  out  1  sticky flag: lane-ID set was invalid
o_loss_counter  out  NB_LOSS_COUNTER  saturating count of alignment losses
o_state  out  3  current FSM state, for debug

Behaviour:
- Reset behaviour: state=IDLE. All outputs are 0 and all counters are 0.
- Output timing: all outputs are registered and reflect the state register (Moore). A transition decided in cycle t shows on the outputs at t+1.
- Priority, highest first: i_reset, then i_enable==0 (forces IDLE next cycle from any state), then the state-specific transitions below.
- State encodings: IDLE=0, WAIT_BLOCK=1, WAIT_AM=2, CHECK_ID=3, ALIGNED=4, RESTART=5. Unused encodings go to IDLE.
- IDLE: all outputs 0 except o_id_error and o_loss_counter, which hold. Moves to WAIT_BLOCK when i_enable=1.
- WAIT_BLOCK:
  - o_aligner_enable=0.
  - When &i_block_lock=1, go to WAIT_AM and clear the timeout counter.
- WAIT_AM:
  - o_aligner_enable=1.
  - Timeout counter increments on i_valid.
  - Any i_block_lock bit low: go to WAIT_BLOCK.
  - Else &i_am_lock=1: go to CHECK_ID.
  - Else i_rf_timeout!=0 and counter+1 >= i_rf_timeout on a valid cycle: go to RESTART.
  - AM lock takes priority over a timeout in the same cycle.
- CHECK_ID: single cycle.
  - Build an N_LANES-bit presence map from the lane IDs; any ID >= N_LANES is invalid.
  - All IDs valid and map all ones (IDs unique and complete): go to ALIGNED.
  - Otherwise set o_id_error and go to RESTART.
- ALIGNED:
  - o_aligner_enable=1, o_deskew_enable=1, o_align_status=1.
  - o_id_error clears on entry.
  - Any i_am_lock or i_block_lock bit low: go to RESTART and increment o_loss_counter, saturating at all ones.
- RESTART: o_restart=1 and o_aligner_enable=0 for exactly one cycle, then WAIT_BLOCK.
- i_enable dropping while in RESTART: o_restart still completes its cycle, then IDLE.
- Reset during any state: IDLE on the next edge, with no o_restart pulse.

Optional Feature:
ALIGN_CTRL_HYST_EN
- Defined: in ALIGNED, a loss condition must hold for 3 consecutive i_valid cycles before RESTART. Non-valid cycles hold the hysteresis counter. A clean valid cycle clears it. The loss counter increments only when RESTART is actually taken.
- Undefined: leaving ALIGNED is immediate on the first loss cycle, as described in Behaviour.

Test Plan:
1. Reset, i_enable=1, all block_lock=1, am_lock=all ones two cycles later, IDs 0..19 in order -> state path 1,2,3,4; o_align_status=1 and o_deskew_enable=1 by cycle ~5; o_id_error=0.
2. IDs with lane 5 = lane 6 = 6 -> CHECK_ID then RESTART; o_restart is high for exactly 1 cycle; o_id_error=1; state returns to WAIT_BLOCK.
3. i_rf_timeout=10, am_lock never asserted, i_valid=1 -> RESTART after 10 valid cycles in WAIT_AM. Repeat with i_rf_timeout=0 -> never times out.
4. In ALIGNED, drop i_am_lock[3] for 1 cycle -> RESTART and o_loss_counter=1. Repeat 300 times -> counter saturates at 255. With ALIGN_CTRL_HYST_EN, a 2-cycle drop stays ALIGNED and a 3-cycle drop restarts.
5. i_enable=0 while in WAIT_AM -> IDLE next cycle; o_aligner_enable=0 and no o_restart pulse.
6. Assert i_reset in ALIGNED -> next cycle all outputs 0 and state=0. Drop i_block_lock[0] in WAIT_AM -> WAIT_BLOCK with o_loss_counter unchanged.
